// File: rtl/alu_scheduler_pkg.sv
// Shared definitions for the two-requester ALU scheduler: requester/width
// constants, FSM state type and ALU op-code encoding.
package alu_sched_pkg;

  localparam int unsigned N_REQ  = 2;  // number of requesters
  localparam int unsigned OPND_W = 4;  // operand width per requester
  localparam int unsigned OP_W   = 3;  // ALU selector width per requester
  localparam int unsigned DATA_W = 8;  // ALU result width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_scheduler_if.sv
// Request/response bundle between the requesters and alu_scheduler.
// Optional rsp_flags exists only when ALU_SCHED_FLAGS_EN is defined.
interface alu_scheduler_if;
  import alu_sched_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*OPND_W-1:0] req_a;
  logic [N_REQ*OPND_W-1:0] req_b;
  logic [N_REQ*OP_W-1:0]   req_op;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]       rsp_data;
  logic                    busy;
  logic [DATA_W-1:0]       op_count;
`ifdef ALU_SCHED_FLAGS_EN
  logic [1:0]              rsp_flags;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, busy, op_count, rsp_flags
  );
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, busy, op_count, rsp_flags
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, busy, op_count
  );
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, busy, op_count
  );
`endif
endinterface

// File: rtl/alu_scheduler_alu.sv
// alu_8bit: purely combinational 8-bit ALU used by the scheduler.
module alu_8bit
  import alu_sched_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] y_o
);

  // Result select; shifts move A by one place with zero fill.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    y_o = '0;
    case (alu_op_e'(op_i))
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NOT:  y_o = ~a_i;
      OP_SHL:  y_o = {a_i[DATA_W-2:0], 1'b0};
      OP_SHR:  y_o = {1'b0, a_i[DATA_W-1:1]};
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin arbiter sharing one alu_8bit between two
// requesters. IDLE grants and latches, EXEC registers the ALU result,
// RESP holds it until the winner accepts.
// Optional build macro: ALU_SCHED_FLAGS_EN adds registered rsp_flags
// ({sign, zero}) alongside rsp_data.
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
)(
  input  logic            clk,
  input  logic            rst,
  alu_scheduler_if.slave  bus
);

  state_e              state_q, state_d;
  logic                prio_q, prio_d;
  logic                winner_q, winner_d;
  logic [OPND_W-1:0]   a_q, a_d;
  logic [OPND_W-1:0]   b_q, b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]   alu_y;
  logic                grant_id;
  logic [N_REQ-1:0]    req_ready_c;
  logic [N_REQ-1:0]    rsp_valid_c;

  // Lone requester wins outright; on contention the priority holder wins.
  assign grant_id = (&bus.req_valid) ? prio_q : bus.req_valid[1];

  alu_8bit u_alu (
    .a_i  ({{(DATA_W-OPND_W){1'b0}}, a_q}),
    .b_i  ({{(DATA_W-OPND_W){1'b0}}, b_q}),
    .op_i (op_q),
    .y_o  (alu_y)
  );

  // Next-state, grant and response decode.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    winner_d    = winner_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    data_d      = data_q;
    count_d     = count_q;
    req_ready_c = '0;
    rsp_valid_c = '0;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          req_ready_c[grant_id] = 1'b1;
          winner_d = grant_id;
          prio_d   = ~grant_id;
          a_d      = grant_id ? bus.req_a[7:4]  : bus.req_a[3:0];
          b_d      = grant_id ? bus.req_b[7:4]  : bus.req_b[3:0];
          op_d     = grant_id ? bus.req_op[5:3] : bus.req_op[2:0];
          state_d  = EXEC;
        end
      end
      EXEC: begin
        data_d  = alu_y;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid_c[winner_q] = 1'b1;
        if (bus.rsp_ready[winner_q]) begin
          count_d = count_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      prio_q   <= RR_INIT;
      winner_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      data_q   <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      prio_q   <= prio_d;
      winner_q <= winner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      data_q   <= data_d;
      count_q  <= count_d;
    end
  end

`ifdef ALU_SCHED_FLAGS_EN
  logic [1:0] flags_q;

  // Flags are captured on the same edge as rsp_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (state_q == EXEC) begin
      flags_q <= {alu_y[DATA_W-1], (alu_y == '0)};
    end
  end

  assign bus.rsp_flags = flags_q;
`endif

  // The grant is combinational, so gate it with reset to clear it at once.
  assign bus.req_ready = rst ? '0 : req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = data_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.op_count  = count_q;

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter RR_INIT, default 0, SHALL select which requester (0/1) holds priority after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 req_valid  input  2  SHALL be the per-requester operation request; bit i = requester i.
REQ-005 req_ready  output  2  SHALL be the per-requester accept strobe; at most one bit high per cycle.
REQ-006 req_a  input  8  SHALL carry 4-bit operand A per requester; requester i on [4i+3:4i].
REQ-007 req_b  input  8  SHALL carry 4-bit operand B per requester, same packing as req_a.
REQ-008 req_op  input  6  SHALL carry the 3-bit ALU selector per requester; requester i on [3i+2:3i].
REQ-009 rsp_valid  output  2  SHALL flag a result for requester i; at most one bit high.
REQ-010 rsp_ready  input  2  SHALL be the per-requester result acceptance.
REQ-011 rsp_data  output  8  SHALL be the registered ALU result, meaningful only while a rsp_valid bit is high.
REQ-012 busy  output  1  SHALL be high whenever the FSM is not IDLE.
REQ-013 op_count  output  8  SHALL count completed responses.

Function
REQ-014 FSM SHALL have states IDLE, EXEC, RESP.
REQ-015 IDLE: if any req_valid, SHALL assert req_ready for exactly one winner that cycle, latch its a/b/op and winner id, go to EXEC; else stay.
REQ-016 Arbitration SHALL be round-robin: single request wins outright; both requesting -> priority holder wins.
REQ-017 Priority SHALL move to the non-winner on every grant.
REQ-018 EXEC: SHALL drive the alu_8bit with {4'b0,A}, {4'b0,B}, op, register Y into rsp_data, go to RESP.
REQ-019 RESP: rsp_valid[winner] SHALL stay high, rsp_data stable, until rsp_ready[winner]; then go to IDLE and increment op_count.
REQ-020 rsp_ready on the non-winner bit, or while not in RESP, SHALL be ignored.
REQ-021 Latency: grant in cycle N -> rsp_valid high from cycle N+2; zero-stall throughput one op per 3 cycles.
REQ-022 req_ready SHALL never be asserted outside IDLE; requests are not accepted while busy.
REQ-023 op_count SHALL wrap 255 -> 0.
REQ-024 Operand/opcode changes after grant SHALL not affect the in-flight result.
REQ-025 Op encoding (alu_8bit): 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SHL A by 1, 111 SHR A by 1; 8-bit results, SUB wraps modulo 256.

Reset
REQ-026 rst SHALL immediately force: state IDLE, req_ready 0, rsp_valid 0, rsp_data 0, busy 0, op_count 0, priority RR_INIT, flags 0.
REQ-027 rst mid-operation SHALL discard the in-flight op without response or count.

Configuration
REQ-028 With ALU_SCHED_FLAGS_EN defined: output rsp_flags (2 bits) SHALL exist, registered with rsp_data: bit0 zero (Y==0), bit1 sign (Y[7]).
REQ-029 Without ALU_SCHED_FLAGS_EN: rsp_flags port and its logic SHALL be absent; all else identical.

Structure
REQ-030 Shared package alu_sched_pkg SHALL hold the FSM state typedef, op-code constants, and requester-count/width constants.
REQ-031 The existing alu_8bit SHALL be the only sub-module instance; arbitration stays inline.

Verification
REQ-032 Req0 only, a=3 b=4 op=000 -> req_ready=01 at N, rsp_valid=01 at N+2, rsp_data=0x07, op_count 1 after rsp_ready.
REQ-033 Both request continuously, RR_INIT=0 -> grants alternate 0,1,0,1; four responses, op_count=4.
REQ-034 Req1 a=2 b=5 op=001, rsp_ready held low 5 cycles -> rsp_data=0xFD stable, rsp_valid=10 held, no new grant.
REQ-035 rst pulsed during EXEC -> all outputs reset values immediately, no response, op_count unchanged at 0.
REQ-036 op_count preloaded by 255 ops, one more op -> op_count=0.
REQ-037 With ALU_SCHED_FLAGS_EN: a=5 b=5 op=100 -> rsp_data=0x00, rsp_flags=01; a=0 b=1 op=001 -> 0xFF, rsp_flags=10.
